serial_monitor: RTL and testbench
=================================

SERIAL_MONITOR -- requirements
Module: serial_monitor

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217, giving UART bit period in clk cycles (25 MHz / 115200).
REQ-002 The block SHALL have parameter TIMEOUT, default 2500000, giving the maximum clk cycles allowed between argument bytes.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rx  in  1  host UART receive line, 8N1, idle high, asynchronous to clk.
REQ-006 tx  out  1  host UART transmit line, 8N1, idle high.
REQ-007 mem_req  out  1  request for ownership of the memory bus.
REQ-008 mem_gnt  in  1  bus granted (top asserts only while CPU paused).
REQ-009 mem_addr  out  16  memory address.
REQ-010 mem_rd  out  1  one-cycle read strobe.
REQ-011 mem_wr  out  1  one-cycle write strobe.
REQ-012 mem_dout  out  8  write data.
REQ-013 mem_din  in  8  read data, valid exactly 1 clk after mem_rd (synchronous memory).
REQ-014 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer before use.
REQ-016 Receiver SHALL detect a falling edge, re-check low at CLKS_PER_BIT/2, then sample 8 data bits LSB first and the stop bit at successive CLKS_PER_BIT intervals.
REQ-017 A received byte with stop bit 0 (framing error) SHALL be discarded; no rx_valid pulse.
REQ-018 Transmitter SHALL send start(0), 8 data bits LSB first, stop(1), each CLKS_PER_BIT cycles; it accepts a byte only when idle.
REQ-019 Command FSM states: IDLE, ARG_HI, ARG_LO, ARG_3, REQ, RD, RD_CAP, TX_DATA, WR, TX_ACK, TX_ERR.
REQ-020 IDLE: byte 0x52 ('R') or 0x57 ('W') -> ARG_HI, latching cmd; any other byte -> TX_ERR.
REQ-021 ARG_HI/ARG_LO latch addr[15:8]/addr[7:0]; ARG_3 latches count (R) or data (W) -> REQ.
REQ-022 In ARG_HI/ARG_LO/ARG_3, if TIMEOUT cycles elapse without a received byte, the FSM SHALL return to IDLE silently; the timeout counter resets on every received byte.
REQ-023 REQ: mem_req=1; remain until mem_gnt=1; then -> RD (R) or WR (W). mem_req SHALL stay 1 in all states after REQ until command completion.
REQ-024 RD: mem_rd=1 for one cycle with mem_addr=addr -> RD_CAP; RD_CAP captures mem_din -> TX_DATA.
REQ-025 TX_DATA: send captured byte; on tx done, addr<=addr+1 (16-bit, 0xFFFF wraps to 0x0000), remaining<=remaining-1; remaining 0 -> IDLE, else -> RD.
REQ-026 count 0x00 SHALL mean 256 bytes (remaining held as 9 bits).
REQ-027 WR: mem_wr=1 for one cycle with mem_addr=addr, mem_dout=data -> TX_ACK.
REQ-028 TX_ACK sends 0x2E ('.') then -> IDLE; TX_ERR sends 0x3F ('?') then -> IDLE.
REQ-029 If mem_gnt drops during a read sequence, the FSM SHALL pause in RD (no strobe) until mem_gnt returns; a byte already captured SHALL still be transmitted.
REQ-030 Bytes received while in REQ, RD, RD_CAP, TX_DATA, WR, TX_ACK or TX_ERR SHALL be discarded.
REQ-031 mem_rd and mem_wr SHALL never be high in the same cycle and SHALL only assert while mem_gnt=1.

Reset
REQ-032 On reset_n=0: FSM IDLE, tx=1, mem_req=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_dout=0, busy=0, receiver/transmitter idle, all counters 0.
REQ-033 Reset asserted mid-command or mid-character SHALL abort immediately; on release the block waits for a fresh start bit.

Verification
REQ-034 mem_gnt=1, mem[0x1000..0x1002]=11,22,33; send 52 10 00 03 -> tx emits 11 22 33, exactly 3 mem_rd pulses, then busy=0.
REQ-035 Send 57 FB 05 A5 -> one mem_wr with mem_addr=0xFB05, mem_dout=0xA5, tx emits 2E.
REQ-036 Send 52 FF FF 02 -> reads at 0xFFFF then 0x0000; send 52 00 00 00 -> 256 bytes returned.
REQ-037 Send 41 -> tx emits 3F; send 52 10 then idle > TIMEOUT cycles -> no output, busy=0, next 57 … accepted normally.
REQ-038 Hold mem_gnt=0, send 52 00 00 01 -> mem_req=1, no mem_rd, no tx; raise mem_gnt -> one byte returned.
REQ-039 Send byte with stop bit 0 -> ignored; assert reset_n=0 mid-read -> tx=1, mem_req=0 within same cycle.

Source files
------------

// File: rtl/serial_monitor.sv
// Host serial monitor: a UART command interface ('R' read / 'W' write) that gives
// a PC access to the 16-bit memory bus while the CPU is paused.
module serial_monitor #(
  parameter int CLKS_PER_BIT = 217,
  parameter int TIMEOUT      = 2500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic        tx,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ARG_HI, ST_ARG_LO, ST_ARG_3, ST_REQ, ST_RD, ST_RD_CAP,
    ST_TX_DATA, ST_WR, ST_TX_ACK, ST_TX_ERR
  } state_t;

  logic          r_rxMeta, r_rxSync, r_rxPrev;
  rxState_t      r_rxState;
  logic [CW-1:0] r_rxCnt;
  logic [2:0]    r_rxBitIdx;
  logic [7:0]    r_rxShift, r_rxByte;
  logic          r_rxValid;

  logic          r_tx, r_txBusy, r_txDone, r_txStart;
  logic [CW-1:0] r_txCnt;
  logic [3:0]    r_txBitIdx;
  logic [8:0]    r_txShift;
  logic [7:0]    r_txData;

  state_t        r_state;
  logic          r_isWrite, r_memReq, r_txIssued;
  logic [15:0]   r_addr;
  logic [7:0]    r_data, r_rdData;
  logic [8:0]    r_remaining;
  logic [TW-1:0] r_toCnt;

  // Receiver: start detected on a falling edge of the synchronised line, then
  // every sample is taken at the centre of its bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxMeta   <= 1'b1;
      r_rxSync   <= 1'b1;
      r_rxPrev   <= 1'b1;
      r_rxState  <= RX_IDLE;
      r_rxCnt    <= '0;
      r_rxBitIdx <= '0;
      r_rxShift  <= '0;
      r_rxByte   <= '0;
      r_rxValid  <= 1'b0;
    end else begin
      r_rxMeta  <= rx;
      r_rxSync  <= r_rxMeta;
      r_rxPrev  <= r_rxSync;
      r_rxValid <= 1'b0;
      case (r_rxState)
        RX_IDLE: begin
          r_rxCnt <= '0;
          if (r_rxPrev && !r_rxSync) r_rxState <= RX_START;
        end
        RX_START: begin
          if (r_rxCnt == HALF_LAST) begin
            r_rxCnt    <= '0;
            r_rxBitIdx <= '0;
            r_rxState  <= r_rxSync ? RX_IDLE : RX_DATA;
          end else begin
            r_rxCnt <= r_rxCnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_rxCnt == BIT_LAST) begin
            r_rxCnt   <= '0;
            r_rxShift <= {r_rxSync, r_rxShift[7:1]};
            if (r_rxBitIdx == 3'd7) r_rxState <= RX_STOP;
            else r_rxBitIdx <= r_rxBitIdx + 3'd1;
          end else begin
            r_rxCnt <= r_rxCnt + CW'(1);
          end
        end
        default: begin
          if (r_rxCnt == BIT_LAST) begin
            r_rxCnt   <= '0;
            r_rxState <= RX_IDLE;
            if (r_rxSync) begin
              r_rxValid <= 1'b1;
              r_rxByte  <= r_rxShift;
            end
          end else begin
            r_rxCnt <= r_rxCnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Transmitter: shift register holds data plus stop bit; the start bit is driven on load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx       <= 1'b1;
      r_txBusy   <= 1'b0;
      r_txDone   <= 1'b0;
      r_txCnt    <= '0;
      r_txBitIdx <= '0;
      r_txShift  <= '0;
    end else begin
      r_txDone <= 1'b0;
      if (!r_txBusy) begin
        if (r_txStart) begin
          r_txBusy   <= 1'b1;
          r_tx       <= 1'b0;
          r_txShift  <= {1'b1, r_txData};
          r_txBitIdx <= '0;
          r_txCnt    <= '0;
        end
      end else if (r_txCnt == BIT_LAST) begin
        r_txCnt <= '0;
        if (r_txBitIdx == 4'd9) begin
          r_txBusy <= 1'b0;
          r_txDone <= 1'b1;
        end else begin
          r_tx       <= r_txShift[0];
          r_txShift  <= {1'b1, r_txShift[8:1]};
          r_txBitIdx <= r_txBitIdx + 4'd1;
        end
      end else begin
        r_txCnt <= r_txCnt + CW'(1);
      end
    end
  end

  // Command FSM; bytes arriving outside IDLE and the argument states are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_isWrite   <= 1'b0;
      r_memReq    <= 1'b0;
      r_txIssued  <= 1'b0;
      r_txStart   <= 1'b0;
      r_txData    <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rdData    <= '0;
      r_remaining <= '0;
      r_toCnt     <= '0;
    end else begin
      r_txStart <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_memReq   <= 1'b0;
          r_txIssued <= 1'b0;
          r_toCnt    <= '0;
          if (r_rxValid) begin
            if (r_rxByte == 8'h52 || r_rxByte == 8'h57) begin
              r_isWrite <= (r_rxByte == 8'h57);
              r_state   <= ST_ARG_HI;
            end else begin
              r_state <= ST_TX_ERR;
            end
          end
        end
        ST_ARG_HI, ST_ARG_LO, ST_ARG_3: begin
          if (r_rxValid) begin
            r_toCnt <= '0;
            if (r_state == ST_ARG_HI) begin
              r_addr[15:8] <= r_rxByte;
              r_state      <= ST_ARG_LO;
            end else if (r_state == ST_ARG_LO) begin
              r_addr[7:0] <= r_rxByte;
              r_state     <= ST_ARG_3;
            end else begin
              if (r_isWrite) r_data <= r_rxByte;
              else r_remaining <= (r_rxByte == 8'h00) ? 9'd256 : {1'b0, r_rxByte};
              r_memReq <= 1'b1;
              r_state  <= ST_REQ;
            end
          end else if (r_toCnt == TO_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_toCnt <= r_toCnt + TW'(1);
          end
        end
        ST_REQ: begin
          if (mem_gnt) r_state <= r_isWrite ? ST_WR : ST_RD;
        end
        ST_RD: begin
          if (mem_gnt) r_state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          r_rdData <= mem_din;
          r_state  <= ST_TX_DATA;
        end
        ST_WR: begin
          if (mem_gnt) r_state <= ST_TX_ACK;
        end
        default: begin
          if (!r_txIssued) begin
            r_txIssued <= 1'b1;
            r_txStart  <= 1'b1;
            r_txData   <= (r_state == ST_TX_DATA) ? r_rdData :
                          (r_state == ST_TX_ACK)  ? 8'h2E : 8'h3F;
          end else if (r_txDone) begin
            r_txIssued <= 1'b0;
            if (r_state == ST_TX_DATA && r_remaining != 9'd1) begin
              r_addr      <= r_addr + 16'd1;
              r_remaining <= r_remaining - 9'd1;
              r_state     <= ST_RD;
            end else begin
              if (r_state == ST_TX_DATA) begin
                r_addr      <= r_addr + 16'd1;
                r_remaining <= r_remaining - 9'd1;
              end
              r_memReq <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Strobes are gated by mem_gnt so they can never fire while the bus is not ours.
  assign mem_rd   = (r_state == ST_RD) && mem_gnt;
  assign mem_wr   = (r_state == ST_WR) && mem_gnt;
  assign mem_addr = r_addr;
  assign mem_dout = r_data;
  assign mem_req  = r_memReq;
  assign tx       = r_tx;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_monitor.sv
// Scoreboard bench for serial_monitor: a command-level model queues expected
// bus strobes and tx bytes, independent monitors pop and compare them.
module tb_serial_monitor;
  localparam int CPB = 8;
  localparam int TO  = 3000;

  logic        clk = 1'b0;
  logic        reset_n, rx, tx, mem_req, mem_gnt, mem_rd, mem_wr, busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout, mem_din;
  logic        gntManual, gntRand, gntRandom;
  bit          monitorEn;

  logic [7:0]  mem    [0:65535];
  logic [7:0]  refMem [0:65535];
  logic [7:0]  expTx [$];
  logic [15:0] expRd [$];
  logic [23:0] expWr [$];
  int checks = 0, errors = 0;
  int rdCount = 0, wrCount = 0, txCount = 0;

  always #5 clk = ~clk;

  assign mem_gnt = gntRandom ? gntRand : gntManual;

  serial_monitor #(.CLKS_PER_BIT(CPB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .tx(tx), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .busy(busy)
  );

  // Synchronous memory: read data appears one clock after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_din <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_dout;
  end

  always @(posedge clk) gntRand <= ($urandom_range(0, 3) != 0);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Bus monitor: every strobe is checked against the next expected access.
  always @(negedge clk) begin
    if (reset_n && monitorEn) begin
      if (mem_rd || mem_wr) begin
        checkOutput("strobe_gnt", 32'(mem_gnt), 32'd1);
        checkOutput("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
      end
      if (mem_rd) begin
        rdCount++;
        if (expRd.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL rd_unexpected: actual addr %h required none", mem_addr);
        end else checkOutput("rd_addr", 32'(mem_addr), 32'(expRd.pop_front()));
      end
      if (mem_wr) begin
        wrCount++;
        if (expWr.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL wr_unexpected: actual addr %h required none", mem_addr);
        end else checkOutput("wr_addr_data", 32'({mem_addr, mem_dout}), 32'(expWr.pop_front()));
      end
    end
  end

  // UART decoder on tx, sampling mid-bit.
  initial begin : txMon
    logic [7:0] b;
    logic stopBit;
    forever begin
      @(negedge tx);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      stopBit = tx;
      if (monitorEn) begin
        txCount++;
        checkOutput("tx_stop", 32'(stopBit), 32'd1);
        if (expTx.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL tx_unexpected: actual byte %h required none", b);
        end else checkOutput("tx_byte", 32'(b), 32'(expTx.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input bit badStop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = !badStop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    if (badStop) repeat (CPB) @(posedge clk);
  endtask

  // Reference model: what a whole command should do on the bus and the tx line.
  task automatic modelCommand(input logic [7:0] c, hi, lo, arg, input int nBytes);
    logic [15:0] a;
    int n;
    if (c != 8'h52 && c != 8'h57) expTx.push_back(8'h3F);
    else if (nBytes >= 4) begin
      a = {hi, lo};
      if (c == 8'h52) begin
        n = (arg == 8'h00) ? 256 : int'(arg);
        for (int i = 0; i < n; i++) begin
          expRd.push_back(a);
          expTx.push_back(refMem[a]);
          a = a + 16'd1;
        end
      end else begin
        expWr.push_back({a, arg});
        refMem[a] = arg;
        expTx.push_back(8'h2E);
      end
    end
  endtask

  task automatic sendCommand(input logic [7:0] c, hi, lo, arg, input int nBytes);
    modelCommand(c, hi, lo, arg, nBytes);
    applyStimulus(c, 1'b0);
    if (nBytes > 1) applyStimulus(hi, 1'b0);
    if (nBytes > 2) applyStimulus(lo, 1'b0);
    if (nBytes > 3) applyStimulus(arg, 1'b0);
  endtask

  task automatic waitIdle(input string name);
    int c = 0;
    while (c < 24000 && (expTx.size() != 0 || expRd.size() != 0 || expWr.size() != 0 || busy)) begin
      @(negedge clk);
      c++;
    end
    checkOutput({name, "_drained"}, 32'(c < 24000), 32'd1);
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("[TB] FAIL watchdog: actual still running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, w0, t0, kind;
    logic [7:0] c;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      refMem[i] = mem[i];
    end
    rx = 1'b1; gntManual = 1'b1; gntRandom = 1'b0; monitorEn = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_dout", 32'(mem_dout), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22; mem[16'h1002] = 8'h33;
    refMem[16'h1000] = 8'h11; refMem[16'h1001] = 8'h22; refMem[16'h1002] = 8'h33;
    r0 = rdCount;
    sendCommand(8'h52, 8'h10, 8'h00, 8'h03, 4);
    waitIdle("read3");
    checkOutput("read3_rd_pulses", 32'(rdCount - r0), 32'd3);
    checkOutput("read3_busy", 32'(busy), 32'd0);

    w0 = wrCount;
    sendCommand(8'h57, 8'hFB, 8'h05, 8'hA5, 4);
    waitIdle("write");
    checkOutput("write_pulses", 32'(wrCount - w0), 32'd1);
    checkOutput("write_mem", 32'(mem[16'hFB05]), 32'hA5);

    r0 = rdCount;
    sendCommand(8'h52, 8'hFF, 8'hFF, 8'h02, 4);
    waitIdle("wrap");
    checkOutput("wrap_rd_pulses", 32'(rdCount - r0), 32'd2);

    r0 = rdCount; t0 = txCount;
    sendCommand(8'h52, 8'h00, 8'h00, 8'h00, 4);
    waitIdle("read256");
    checkOutput("read256_rd_pulses", 32'(rdCount - r0), 32'd256);
    checkOutput("read256_tx_bytes", 32'(txCount - t0), 32'd256);

    sendCommand(8'h41, 8'h00, 8'h00, 8'h00, 1);
    waitIdle("bad_cmd");

    t0 = txCount;
    sendCommand(8'h52, 8'h10, 8'h00, 8'h00, 2);
    checkOutput("timeout_busy_in_args", 32'(busy), 32'd1);
    repeat (TO + 200) @(negedge clk);
    checkOutput("timeout_busy_after", 32'(busy), 32'd0);
    checkOutput("timeout_no_tx", 32'(txCount - t0), 32'd0);
    sendCommand(8'h57, 8'h12, 8'h34, 8'h5A, 4);
    waitIdle("after_timeout");
    checkOutput("after_timeout_mem", 32'(mem[16'h1234]), 32'h5A);

    gntManual = 1'b0;
    r0 = rdCount; t0 = txCount;
    sendCommand(8'h52, 8'h00, 8'h00, 8'h01, 4);
    repeat (300) @(negedge clk);
    checkOutput("nognt_mem_req", 32'(mem_req), 32'd1);
    checkOutput("nognt_no_rd", 32'(rdCount - r0), 32'd0);
    checkOutput("nognt_no_tx", 32'(txCount - t0), 32'd0);
    gntManual = 1'b1;
    waitIdle("gnt_returned");
    checkOutput("gnt_returned_rd_pulses", 32'(rdCount - r0), 32'd1);

    applyStimulus(8'h52, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("framing_ignored", 32'(busy), 32'd0);
    sendCommand(8'h3C, 8'h00, 8'h00, 8'h00, 1);
    waitIdle("after_framing");

    gntRandom = 1'b1;
    for (int k = 0; k < 15; k++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        c = 8'($urandom);
        if (c == 8'h52 || c == 8'h57) c = 8'h00;
        sendCommand(c, 8'h00, 8'h00, 8'h00, 1);
      end else if (kind < 5) begin
        sendCommand(8'h52, 8'($urandom), 8'($urandom), 8'($urandom_range(1, 4)), 4);
      end else begin
        sendCommand(8'h57, 8'($urandom), 8'($urandom), 8'($urandom), 4);
      end
      waitIdle("random");
    end
    gntRandom = 1'b0;

    sendCommand(8'h52, 8'h20, 8'h00, 8'h04, 4);
    for (int k = 0; k < 3000 && tx !== 1'b0; k++) @(negedge clk);
    checkOutput("midread_tx_started", 32'(tx), 32'd0);
    repeat (3 * CPB) @(negedge clk);
    monitorEn = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midread_rst_tx", 32'(tx), 32'd1);
    checkOutput("midread_rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("midread_rst_busy", 32'(busy), 32'd0);
    expTx.delete(); expRd.delete(); expWr.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    monitorEn = 1'b1;
    sendCommand(8'h41, 8'h00, 8'h00, 8'h00, 1);
    waitIdle("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
